// File: rtl/agc_loop_ctrl_if.sv
// Sample/coefficient/lock bus between the AGC loop controller and its environment.
// slave is the controller's view; master is the driving side (config, detector, error datapath).
interface agc_loop_ctrl_if #(
  parameter int BWIDTH   = 18,
  parameter int AWIDTH   = 30,
  parameter int DWIDTH   = 27,
  parameter int OUTWIDTH = 48,
  parameter int CNTW     = 16
) ();
  logic                  en;
  logic                  freeze;
  logic [AWIDTH-1:0]     Sample_In;
  logic                  Sample_Valid;
  logic [BWIDTH-1:0]     Coeff_Acq;
  logic [BWIDTH-1:0]     Coeff_Trk;
  logic [DWIDTH-1:0]     R_level_cfg;
  logic [CNTW-1:0]       Acq_Len;
  logic [OUTWIDTH-2:0]   Lock_Thresh;
  logic [CNTW-1:0]       Lock_Count;
  logic [OUTWIDTH-1:0]   Error_Out;
  logic                  Valid_out_error;
  logic [AWIDTH-1:0]     Port_Data_A;
  logic [BWIDTH-1:0]     Error_Coefficient;
  logic [DWIDTH-1:0]     R_level;
  logic                  Valid;
  logic [1:0]            State;
  logic                  Locked;
  logic                  Acq_Done;

  modport slave (
    input  en, freeze, Sample_In, Sample_Valid, Coeff_Acq, Coeff_Trk, R_level_cfg,
           Acq_Len, Lock_Thresh, Lock_Count, Error_Out, Valid_out_error,
    output Port_Data_A, Error_Coefficient, R_level, Valid, State, Locked, Acq_Done
  );

  modport master (
    output en, freeze, Sample_In, Sample_Valid, Coeff_Acq, Coeff_Trk, R_level_cfg,
           Acq_Len, Lock_Thresh, Lock_Count, Error_Out, Valid_out_error,
    input  Port_Data_A, Error_Coefficient, R_level, Valid, State, Locked, Acq_Done
  );
endinterface

// File: rtl/agc_loop_ctrl.sv
// AGC loop controller: sequences acquisition/tracking, feeds the error datapath
// and watches the returned error accumulator for lock.
//
// state | meaning
// IDLE  | loop disabled, samples dropped
// ACQ   | forwarding samples with the acquisition coefficient
// TRACK | forwarding samples with the tracking coefficient, lock monitor live
// HOLD  | frozen, no samples forwarded, lock status retained
module agc_loop_ctrl #(
  parameter int BWIDTH   = 18,
  parameter int AWIDTH   = 30,
  parameter int DWIDTH   = 27,
  parameter int OUTWIDTH = 48,
  parameter int CNTW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  agc_loop_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     acq_cnt_q, acq_cnt_d;
  logic                fwd, acq_last, load_ref;

  logic                valid_q, acq_done_q;
  logic [AWIDTH-1:0]   pda_q;
  logic [BWIDTH-1:0]   coef_q;
  logic [DWIDTH-1:0]   rlev_q;

  logic [OUTWIDTH-1:0]      prev_q;
  logic                     have_prev_q;
  logic [CNTW-1:0]          lock_cnt_q;
  logic                     locked_q;
  logic [CNTW-1:0]          lock_tgt, cnt_inc;
  logic signed [OUTWIDTH:0] err_ext, prev_ext, delta;
  logic [OUTWIDTH:0]        mag;
  logic                     in_thresh;

  always_comb begin
    state_d   = state_q;
    acq_cnt_d = acq_cnt_q;
    fwd       = 1'b0;
    acq_last  = 1'b0;
    load_ref  = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
    end else if (bus.freeze && (state_q == ACQ || state_q == TRACK)) begin
      state_d = HOLD;
    end else begin
      unique case (state_q)
        IDLE: begin
          // a frozen loop is not started
          if (!bus.freeze) begin
            state_d   = ACQ;
            load_ref  = 1'b1;
            acq_cnt_d = (bus.Acq_Len == '0) ? CNTW'(1) : bus.Acq_Len;
          end
        end
        ACQ: begin
          if (bus.Sample_Valid) begin
            fwd = 1'b1;
            if (acq_cnt_q <= CNTW'(1)) begin
              acq_last = 1'b1;
              state_d  = TRACK;
            end else begin
              acq_cnt_d = acq_cnt_q - CNTW'(1);
            end
          end
        end
        TRACK: fwd = bus.Sample_Valid;
        HOLD: begin
          if (!bus.freeze) state_d = TRACK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acq_cnt_q  <= '0;
      valid_q    <= 1'b0;
      acq_done_q <= 1'b0;
      pda_q      <= '0;
      coef_q     <= '0;
      rlev_q     <= '0;
    end else begin
      state_q    <= state_d;
      acq_cnt_q  <= acq_cnt_d;
      valid_q    <= fwd;
      acq_done_q <= acq_last;
      if (fwd) begin
        pda_q  <= bus.Sample_In;
        coef_q <= (state_q == ACQ) ? bus.Coeff_Acq : bus.Coeff_Trk;
      end
      if (load_ref) rlev_q <= bus.R_level_cfg;
    end
  end

  // Delta is taken one bit wider than the accumulator so it can never wrap.
  assign err_ext   = {bus.Error_Out[OUTWIDTH-1], bus.Error_Out};
  assign prev_ext  = {prev_q[OUTWIDTH-1], prev_q};
  assign delta     = err_ext - prev_ext;
  assign mag       = delta[OUTWIDTH] ? $unsigned(-delta) : $unsigned(delta);
  assign in_thresh = (mag <= {2'b00, bus.Lock_Thresh});
  assign lock_tgt  = (bus.Lock_Count == '0) ? CNTW'(1) : bus.Lock_Count;
  assign cnt_inc   = (lock_cnt_q >= lock_tgt) ? lock_tgt : lock_cnt_q + CNTW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      if (bus.Valid_out_error) prev_q <= bus.Error_Out;
      if (!bus.en || state_q != TRACK) have_prev_q <= 1'b0;
      else if (bus.Valid_out_error)    have_prev_q <= 1'b1;
      if (!bus.en) begin
        lock_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else if (bus.Valid_out_error && state_q == TRACK && have_prev_q) begin
        if (in_thresh) begin
          lock_cnt_q <= cnt_inc;
          locked_q   <= (cnt_inc == lock_tgt);
        end else begin
          lock_cnt_q <= '0;
          locked_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.Port_Data_A       = pda_q;
  assign bus.Error_Coefficient = coef_q;
  assign bus.R_level           = rlev_q;
  assign bus.Valid             = valid_q;
  assign bus.State             = state_q;
  assign bus.Locked            = locked_q;
  assign bus.Acq_Done          = acq_done_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Bench for agc_loop_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the loop rules.
module tb_agc_loop_ctrl;
  localparam int BWIDTH   = 18;
  localparam int AWIDTH   = 30;
  localparam int DWIDTH   = 27;
  localparam int OUTWIDTH = 48;
  localparam int CNTW     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  agc_loop_ctrl_if #(.BWIDTH(BWIDTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
                     .OUTWIDTH(OUTWIDTH), .CNTW(CNTW)) bus ();

  agc_loop_ctrl #(.BWIDTH(BWIDTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
                  .OUTWIDTH(OUTWIDTH), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural model: state as 0..3, lock kept as a plain run length
  int                m_state;
  int                m_acq_left;
  logic [DWIDTH-1:0] m_rlevel;
  logic [AWIDTH-1:0] m_pda;
  logic [BWIDTH-1:0] m_coef;
  bit                m_valid, m_done, m_locked, m_have_prev;
  int                m_lcnt;
  longint            m_prev;

  function automatic void model_reset();
    m_state = 0; m_acq_left = 0; m_rlevel = '0; m_pda = '0; m_coef = '0;
    m_valid = 0; m_done = 0; m_locked = 0; m_have_prev = 0; m_lcnt = 0; m_prev = 0;
  endfunction

  function automatic void model_step();
    int     ns, nleft, nlcnt, tgt;
    bit     take, ndone, nlocked, nhave;
    longint e, d;
    if (rst) begin
      model_reset();
      return;
    end
    take  = bus.en && !bus.freeze && (m_state == 1 || m_state == 2) && bus.Sample_Valid;
    ns    = m_state;
    nleft = m_acq_left;
    ndone = 0;
    if (!bus.en) ns = 0;
    else if (bus.freeze) ns = (m_state == 0) ? 0 : 3;
    else if (m_state == 0) begin
      ns = 1;
      nleft = (bus.Acq_Len == 0) ? 1 : int'(bus.Acq_Len);
      m_rlevel = bus.R_level_cfg;
    end else if (m_state == 3) ns = 2;
    else if (m_state == 1 && take) begin
      nleft = m_acq_left - 1;
      if (nleft == 0) begin ns = 2; ndone = 1; end
    end

    nlcnt   = m_lcnt;
    nlocked = m_locked;
    nhave   = (bus.en && m_state == 2) ? m_have_prev : 1'b0;
    if (bus.Valid_out_error) begin
      e = longint'($signed(bus.Error_Out));
      if (bus.en && m_state == 2) begin
        if (m_have_prev) begin
          d = e - m_prev;
          if (d < 0) d = -d;
          tgt = (bus.Lock_Count == 0) ? 1 : int'(bus.Lock_Count);
          if (d <= longint'(bus.Lock_Thresh)) begin
            nlcnt   = (m_lcnt + 1 > tgt) ? tgt : m_lcnt + 1;
            nlocked = (nlcnt == tgt);
          end else begin
            nlcnt = 0; nlocked = 0;
          end
        end
        nhave = 1;
      end
      m_prev = e;
    end
    if (!bus.en) begin nlcnt = 0; nlocked = 0; end

    m_valid = take;
    if (take) begin
      m_pda  = bus.Sample_In;
      m_coef = (m_state == 1) ? bus.Coeff_Acq : bus.Coeff_Trk;
    end
    m_done = ndone; m_state = ns; m_acq_left = nleft;
    m_lcnt = nlcnt; m_locked = nlocked; m_have_prev = nhave;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en = 0; bus.freeze = 0; bus.Sample_In = '0; bus.Sample_Valid = 0;
    bus.Coeff_Acq = '0; bus.Coeff_Trk = '0; bus.R_level_cfg = '0; bus.Acq_Len = '0;
    bus.Lock_Thresh = '0; bus.Lock_Count = '0; bus.Error_Out = '0; bus.Valid_out_error = 0;
  endtask

  task automatic set_err(input longint v);
    bus.Error_Out = v[OUTWIDTH-1:0];
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.en = 1; bus.Sample_Valid = 1; bus.R_level_cfg = 'h1ff;
    rst = 1; tick(); tick();
    checks++; if (bus.State !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.State); end
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.Valid); end
    checks++; if (bus.Locked !== 1'b0 || bus.Acq_Done !== 1'b0) begin errors++; $display("FAIL reset_flags locked=%b done=%b exp=0", bus.Locked, bus.Acq_Done); end
    checks++; if (bus.Port_Data_A !== '0 || bus.Error_Coefficient !== '0 || bus.R_level !== '0) begin
      errors++; $display("FAIL reset_data pda=%h coef=%h rlev=%h exp=0", bus.Port_Data_A, bus.Error_Coefficient, bus.R_level); end
    rst = 0;
  endtask

  task automatic test_acq_to_track();
    int n_acq = 0, n_trk = 0, n_done = 0, pulses = 0;
    do_reset();
    bus.Acq_Len = 4; bus.Coeff_Acq = 'h100; bus.Coeff_Trk = 'h10; bus.R_level_cfg = 'h1234;
    bus.Sample_Valid = 1; bus.en = 1;
    for (int i = 0; i < 8; i++) begin
      bus.Sample_In = AWIDTH'(1000 + i);
      tick();
      bus.R_level_cfg = 'h777;
      if (bus.Valid) begin
        pulses++;
        checks++; if (bus.Port_Data_A !== AWIDTH'(1000 + i)) begin errors++; $display("FAIL acq_pda got=%0d exp=%0d", bus.Port_Data_A, 1000 + i); end
        if (bus.Error_Coefficient == 'h100) n_acq++;
        else if (bus.Error_Coefficient == 'h10) n_trk++;
      end
      if (bus.Acq_Done) begin
        n_done++;
        checks++; if (pulses !== 4) begin errors++; $display("FAIL acq_done_pos got=%0d exp=4", pulses); end
      end
    end
    checks++; if (n_acq !== 4) begin errors++; $display("FAIL acq_coef_pulses got=%0d exp=4", n_acq); end
    checks++; if (n_trk !== 3) begin errors++; $display("FAIL trk_coef_pulses got=%0d exp=3", n_trk); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL acq_done_count got=%0d exp=1", n_done); end
    checks++; if (bus.State !== 2'd2) begin errors++; $display("FAIL acq_end_state got=%0d exp=2", bus.State); end
    checks++; if (bus.R_level !== DWIDTH'('h1234)) begin errors++; $display("FAIL rlevel_hold got=%h exp=1234", bus.R_level); end
  endtask

  task automatic test_lock();
    longint vals[8] = '{100, 102, 104, 105, 200, 205, 210, 215};
    bit     expl[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bus.Sample_Valid = 0; bus.Lock_Thresh = 5; bus.Lock_Count = 3;
    bus.Valid_out_error = 1;
    for (int i = 0; i < 8; i++) begin
      set_err(vals[i]);
      tick();
      checks++; if (bus.Locked !== expl[i]) begin errors++; $display("FAIL lock_seq[%0d] got=%b exp=%b", i, bus.Locked, expl[i]); end
    end
    bus.Valid_out_error = 0;
  endtask

  task automatic test_min_len();
    int n_acq = 0, n_done = 0;
    do_reset();
    bus.Acq_Len = 0; bus.Lock_Count = 0; bus.Lock_Thresh = 5;
    bus.Coeff_Acq = 'h3; bus.Coeff_Trk = 'h4; bus.Sample_Valid = 1; bus.en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.Valid && bus.Error_Coefficient == 'h3) n_acq++;
      if (bus.Acq_Done) n_done++;
    end
    checks++; if (n_acq !== 1 || n_done !== 1) begin errors++; $display("FAIL minlen_acq samples=%0d done=%0d exp=1/1", n_acq, n_done); end
    checks++; if (bus.State !== 2'd2) begin errors++; $display("FAIL minlen_state got=%0d exp=2", bus.State); end
    bus.Sample_Valid = 0; bus.Valid_out_error = 1;
    set_err(-50); tick();
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL lockcnt0_first got=%b exp=0", bus.Locked); end
    set_err(-47); tick();
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL lockcnt0_second got=%b exp=1", bus.Locked); end
    bus.Valid_out_error = 0;
  endtask

  task automatic test_freeze();
    do_reset();
    bus.Acq_Len = 20; bus.Coeff_Acq = 'h100; bus.Coeff_Trk = 'h10; bus.Sample_Valid = 1; bus.en = 1;
    tick(); tick(); tick();
    bus.freeze = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0 || bus.State !== 2'd3) begin errors++; $display("FAIL freeze_hold[%0d] valid=%b state=%0d exp=0/3", i, bus.Valid, bus.State); end
    end
    bus.freeze = 0;
    tick();
    checks++; if (bus.State !== 2'd2 || bus.Valid !== 1'b0 || bus.Locked !== 1'b0) begin
      errors++; $display("FAIL unfreeze state=%0d valid=%b locked=%b exp=2/0/0", bus.State, bus.Valid, bus.Locked); end
    tick();
    checks++; if (bus.Valid !== 1'b1 || bus.Error_Coefficient !== BWIDTH'('h10)) begin
      errors++; $display("FAIL unfreeze_trk valid=%b coef=%h exp=1/10", bus.Valid, bus.Error_Coefficient); end
    bus.Sample_Valid = 0; bus.Lock_Thresh = 5; bus.Lock_Count = 2; bus.Valid_out_error = 1;
    set_err(0); tick(); set_err(1); tick(); set_err(2); tick();
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL freeze_prelock got=%b exp=1", bus.Locked); end
    bus.Valid_out_error = 0; bus.freeze = 1; tick();
    bus.Valid_out_error = 1; set_err(1000); tick();
    bus.Valid_out_error = 0; tick();
    checks++; if (bus.Locked !== 1'b1 || bus.State !== 2'd3) begin errors++; $display("FAIL hold_keeps_lock locked=%b state=%0d exp=1/3", bus.Locked, bus.State); end
    bus.freeze = 0; tick();
    checks++; if (bus.Locked !== 1'b1 || bus.State !== 2'd2) begin errors++; $display("FAIL hold_exit locked=%b state=%0d exp=1/2", bus.Locked, bus.State); end
    bus.Valid_out_error = 1;
    set_err(5000); tick();
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL reentry_first got=%b exp=1", bus.Locked); end
    set_err(5001); tick();
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL reentry_sat got=%b exp=1", bus.Locked); end
    set_err(9000); tick();
    checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL reentry_unlock got=%b exp=0", bus.Locked); end
    bus.Valid_out_error = 0;
  endtask

  task automatic test_disable();
    do_reset();
    bus.Acq_Len = 1; bus.Sample_Valid = 1; bus.en = 1; bus.Lock_Count = 1; bus.Lock_Thresh = 5;
    tick(); tick();
    bus.Valid_out_error = 1; set_err(10); tick(); set_err(11); tick();
    checks++; if (bus.Locked !== 1'b1) begin errors++; $display("FAIL dis_prelock got=%b exp=1", bus.Locked); end
    bus.Valid_out_error = 0; bus.en = 0; tick();
    checks++; if (bus.State !== 2'd0 || bus.Locked !== 1'b0 || bus.Valid !== 1'b0) begin
      errors++; $display("FAIL disable state=%0d locked=%b valid=%b exp=0/0/0", bus.State, bus.Locked, bus.Valid); end
    bus.Valid_out_error = 1;
    for (int i = 0; i < 2; i++) begin
      set_err(12 + i); tick();
      checks++; if (bus.Locked !== 1'b0) begin errors++; $display("FAIL dis_tail[%0d] got=%b exp=0", i, bus.Locked); end
    end
    bus.Valid_out_error = 0; bus.R_level_cfg = 'h55; bus.en = 1; tick();
    checks++; if (bus.State !== 2'd1 || bus.R_level !== DWIDTH'('h55)) begin
      errors++; $display("FAIL reenable state=%0d rlev=%h exp=1/55", bus.State, bus.R_level); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.Acq_Len = 8; bus.Coeff_Acq = 'h155; bus.R_level_cfg = 'h2aa; bus.Sample_In = 'h1234;
    bus.Sample_Valid = 1; bus.en = 1;
    tick(); tick(); tick();
    #3;
    rst = 1;
    #1;
    checks++; if (bus.State !== 2'd0 || bus.Valid !== 1'b0 || bus.Acq_Done !== 1'b0 || bus.Locked !== 1'b0) begin
      errors++; $display("FAIL async_rst_ctrl state=%0d valid=%b done=%b locked=%b exp=0", bus.State, bus.Valid, bus.Acq_Done, bus.Locked); end
    checks++; if (bus.Port_Data_A !== '0 || bus.Error_Coefficient !== '0 || bus.R_level !== '0) begin
      errors++; $display("FAIL async_rst_data pda=%h coef=%h rlev=%h exp=0", bus.Port_Data_A, bus.Error_Coefficient, bus.R_level); end
    tick();
    rst = 0; bus.en = 0; bus.Valid_out_error = 1;
    set_err(7); tick(); set_err(8); tick();
    checks++; if (bus.Locked !== 1'b0 || bus.State !== 2'd0) begin errors++; $display("FAIL rst_tail locked=%b state=%0d exp=0/0", bus.Locked, bus.State); end
    bus.Valid_out_error = 0;
    model_reset();
  endtask

  task automatic test_random();
    longint err = -40;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus.en = ($urandom_range(0, 99) < 97);
      if (bus.freeze) bus.freeze = ($urandom_range(0, 9) < 7);
      else            bus.freeze = ($urandom_range(0, 99) < 4);
      bus.Sample_Valid = ($urandom_range(0, 9) < 6);
      bus.Sample_In    = AWIDTH'($urandom);
      bus.Coeff_Acq    = BWIDTH'($urandom);
      bus.Coeff_Trk    = BWIDTH'($urandom);
      bus.R_level_cfg  = DWIDTH'($urandom);
      bus.Acq_Len      = CNTW'($urandom_range(0, 6));
      if (i % 200 == 0) begin
        bus.Lock_Thresh = (OUTWIDTH-1)'($urandom_range(3, 15));
        bus.Lock_Count  = CNTW'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 19) == 0) err = err + longint'($urandom_range(0, 4000)) - 2000;
      else                            err = err + longint'($urandom_range(0, 8)) - 4;
      set_err(err);
      bus.Valid_out_error = $urandom_range(0, 1) == 1;
      tick();
      checks++; if (bus.State !== 2'(m_state)) begin errors++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, bus.State, m_state); end
      checks++; if (bus.Valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.Valid, m_valid); end
      checks++; if (bus.Port_Data_A !== m_pda) begin errors++; $display("FAIL rnd_pda cyc=%0d got=%h exp=%h", i, bus.Port_Data_A, m_pda); end
      checks++; if (bus.Error_Coefficient !== m_coef) begin errors++; $display("FAIL rnd_coef cyc=%0d got=%h exp=%h", i, bus.Error_Coefficient, m_coef); end
      checks++; if (bus.R_level !== m_rlevel) begin errors++; $display("FAIL rnd_rlevel cyc=%0d got=%h exp=%h", i, bus.R_level, m_rlevel); end
      checks++; if (bus.Acq_Done !== m_done) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, bus.Acq_Done, m_done); end
      checks++; if (bus.Locked !== m_locked) begin errors++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", i, bus.Locked, m_locked); end
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_acq_to_track();
    test_lock();
    test_min_len();
    test_freeze();
    test_disable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
